btn_conditioner: RTL and testbench
==================================

BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1_000_000, is the number of consecutive stable clk cycles needed to accept a press or release (10 ms at 100 MHz); legal range 2..2^24-1.
REQ-002 Parameter NUM_LEVELS, default 4, is the number of difficulty levels; legal range 2..4.
REQ-003 Port clk, input, 1 bit: board clock; the only clock; all flops are posedge clk.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port pause_btn, input, 1 bit: raw, asynchronous, bouncing pause push-button, high = pressed.
REQ-006 Port lev_btn, input, 1 bit: raw, asynchronous, bouncing level push-button, high = pressed.
REQ-007 Port pause_state, output, 1 bit: registered game-paused level, feeding the display pause input.
REQ-008 Port pause_pulse, output, 1 bit: one-cycle strobe for each accepted pause press.
REQ-009 Port lev_pulse, output, 1 bit: one-cycle strobe for each accepted level press, feeding the clock divider level input.
REQ-010 Port lev_sel, output, 2 bits: current difficulty level, 0..NUM_LEVELS-1.

Function
REQ-011 Each button input shall pass through its own two-flop synchronizer before any other logic uses it.
REQ-012 Each button shall have its own debounce FSM with the states IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT, plus its own 24-bit stable-cycle counter.
REQ-013 IDLE: if the synced input is 1, go to PRESS_WAIT and clear the counter to 0; otherwise stay in IDLE.
REQ-014 PRESS_WAIT: if the synced input is 0, return to IDLE and clear the counter.
REQ-015 PRESS_WAIT: if the synced input is 1 and counter == DEBOUNCE_CYCLES-1, go to PRESSED and register the strobe; otherwise increment the counter.
REQ-016 PRESSED: if the synced input is 0, go to RELEASE_WAIT and clear the counter; otherwise hold.
REQ-017 RELEASE_WAIT: if the synced input is 1, return to PRESSED and clear the counter.
REQ-018 RELEASE_WAIT: if the synced input is 0 and counter == DEBOUNCE_CYCLES-1, go to IDLE; otherwise increment the counter.
REQ-019 Press latency: the strobe shall be high for exactly one cycle, DEBOUNCE_CYCLES+3 rising edges after the first edge that samples the raw input high, provided the input stays high throughout.
REQ-020 A held button shall produce exactly one strobe; a new strobe requires a full debounced release first.
REQ-021 pause_state shall toggle on the clk edge after pause_pulse is high, so it changes one cycle after the strobe.
REQ-022 lev_sel shall increment on the edge after lev_pulse and wrap from NUM_LEVELS-1 to 0.
REQ-023 The two channels are independent; simultaneous strobes shall both take effect in the same cycle.
REQ-024 All outputs shall be registered, with no combinational path from any input to any output.
REQ-025 The counters shall never exceed DEBOUNCE_CYCLES-1.

Reset
REQ-026 While rst is high at a clk edge, both FSMs shall go to IDLE, and the counters and synchronizer flops shall be cleared.
REQ-027 While rst is high at a clk edge, pause_state, pause_pulse, lev_pulse and lev_sel shall all be cleared to 0.
REQ-028 A reset asserted mid-debounce or mid-press shall abort the operation with no strobe.
REQ-029 After reset, a button still held shall be treated as a new press and strobe after the full latency.

Structure
REQ-030 The FSM state encoding (2 bits) and the default DEBOUNCE_CYCLES and NUM_LEVELS values shall live in the shared game package.
REQ-031 The debounce channel (synchronizer, FSM, counter, strobe) shall be one sub-module, debounce_fsm, instantiated twice; the toggle and level logic stay in btn_conditioner.

Verification (DEBOUNCE_CYCLES=4, NUM_LEVELS=4)
REQ-032 Clean press: pause_btn rises and holds for 20 cycles -> pause_pulse is high for 1 cycle at edge 7, pause_state goes 0->1 at edge 8, with no further strobe.
REQ-033 Bounce: pause_btn toggles 1,0,1,0 on successive cycles, then holds at 1 -> exactly one pause_pulse, 7 edges after the final rise.
REQ-034 Level wrap: five debounced lev_btn presses -> lev_sel steps 1,2,3,0,1, with 5 lev_pulse strobes.
REQ-035 Release glitch: hold for 10 cycles, drop to 0 for 2 cycles, then rise to 1 -> no second strobe.
REQ-036 Simultaneous: both buttons rise on the same edge -> pause_pulse and lev_pulse both high in the same cycle, then pause_state=1 and lev_sel=1.
REQ-037 Reset mid-operation: rst is pulsed 2 cycles after the press enters PRESS_WAIT while the button stays held -> no strobe at the original time, and one strobe 7 edges after rst deasserts.

Source files
------------

// File: rtl/btn_conditioner_pkg.sv
// rtl/btn_conditioner_pkg.sv - shared debounce state encoding and default game parameters
package btn_conditioner_pkg;

    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_NUM_LEVELS      = 4;
    localparam int CNT_W               = 24;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } db_state_t;

endpackage

// File: rtl/btn_conditioner_if.sv
// rtl/btn_conditioner_if.sv - button inputs and conditioned outputs bundle
interface btn_conditioner_if;

    logic       pause_btn;
    logic       lev_btn;
    logic       pause_state;
    logic       pause_pulse;
    logic       lev_pulse;
    logic [1:0] lev_sel;

    modport master (
        output pause_btn, lev_btn,
        input  pause_state, pause_pulse, lev_pulse, lev_sel
    );

    modport slave (
        input  pause_btn, lev_btn,
        output pause_state, pause_pulse, lev_pulse, lev_sel
    );

endinterface

// File: rtl/debounce_fsm.sv
// rtl/debounce_fsm.sv - one button channel: synchronizer, debounce FSM, stable counter, press strobe
module debounce_fsm
    import btn_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic pulse_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    db_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    // Any disagreement with the pending level restarts the stable-cycle count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sync2_q) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!sync2_q) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PRESSED: begin
                if (!sync2_q) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                if (sync2_q) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - pause toggle and wrapping level select driven by two debounced buttons
module btn_conditioner
    import btn_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int NUM_LEVELS      = DEF_NUM_LEVELS
) (
    input  logic                clk,
    input  logic                rst,
    btn_conditioner_if.slave    bus
);

    localparam logic [1:0] LEV_MAX = 2'(NUM_LEVELS - 1);

    logic       pause_pulse;
    logic       lev_pulse;
    logic       pause_state_q, pause_state_d;
    logic [1:0] lev_sel_q, lev_sel_d;

    debounce_fsm #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause_db (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (bus.pause_btn),
        .pulse_o (pause_pulse)
    );

    debounce_fsm #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lev_db (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (bus.lev_btn),
        .pulse_o (lev_pulse)
    );

    always_comb begin
        pause_state_d = pause_state_q;
        lev_sel_d     = lev_sel_q;
        if (pause_pulse) begin
            pause_state_d = ~pause_state_q;
        end
        if (lev_pulse) begin
            lev_sel_d = (lev_sel_q == LEV_MAX) ? 2'd0 : lev_sel_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pause_state_q <= 1'b0;
            lev_sel_q     <= 2'd0;
        end else begin
            pause_state_q <= pause_state_d;
            lev_sel_q     <= lev_sel_d;
        end
    end

    assign bus.pause_state = pause_state_q;
    assign bus.pause_pulse = pause_pulse;
    assign bus.lev_pulse   = lev_pulse;
    assign bus.lev_sel     = lev_sel_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// tb/tb_btn_conditioner.sv - directed bench for btn_conditioner with DEBOUNCE_CYCLES=4, NUM_LEVELS=4
module tb_btn_conditioner;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   lev_pulses;
    logic [1:0] lev_tab [5];

    btn_conditioner_if bus ();

    btn_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .NUM_LEVELS      (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Edge k counts from the first edge sampling the current inputs; *_at = 0 means no strobe.
    task automatic watch(input string tag, input int n, input int pp_at, input int lp_at,
                         input logic ps0, input logic ps1,
                         input logic [1:0] ls0, input logic [1:0] ls1);
        for (int k = 1; k <= n; k++) begin
            tick();
            if (bus.lev_pulse === 1'b1) lev_pulses++;
            chk({tag, "_pause_pulse"}, 8'(bus.pause_pulse), 8'(k == pp_at));
            chk({tag, "_lev_pulse"},   8'(bus.lev_pulse),   8'(k == lp_at));
            chk({tag, "_pause_state"}, 8'(bus.pause_state), 8'((pp_at > 0 && k > pp_at) ? ps1 : ps0));
            chk({tag, "_lev_sel"},     8'(bus.lev_sel),     8'((lp_at > 0 && k > lp_at) ? ls1 : ls0));
        end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        lev_pulses    = 0;
        lev_tab       = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        rst           = 1'b1;
        bus.pause_btn = 1'b0;
        bus.lev_btn   = 1'b0;
        tick(); tick(); tick();
        chk("rst_pause_state", 8'(bus.pause_state), 8'h0);
        chk("rst_pause_pulse", 8'(bus.pause_pulse), 8'h0);
        chk("rst_lev_pulse",   8'(bus.lev_pulse),   8'h0);
        chk("rst_lev_sel",     8'(bus.lev_sel),     8'h0);
        rst = 1'b0;

        // Clean press held 20 cycles, then release
        bus.pause_btn = 1'b1;
        watch("clean", 20, 7, 0, 1'b0, 1'b1, 2'd0, 2'd0);
        bus.pause_btn = 1'b0;
        watch("clean_rel", 12, 0, 0, 1'b1, 1'b1, 2'd0, 2'd0);

        // Bounce 1,0,1,0 then hold
        bus.pause_btn = 1'b1; watch("bounce1", 1, 0, 0, 1'b1, 1'b1, 2'd0, 2'd0);
        bus.pause_btn = 1'b0; watch("bounce2", 1, 0, 0, 1'b1, 1'b1, 2'd0, 2'd0);
        bus.pause_btn = 1'b1; watch("bounce3", 1, 0, 0, 1'b1, 1'b1, 2'd0, 2'd0);
        bus.pause_btn = 1'b0; watch("bounce4", 1, 0, 0, 1'b1, 1'b1, 2'd0, 2'd0);
        bus.pause_btn = 1'b1;
        watch("bounce_hold", 14, 7, 0, 1'b1, 1'b0, 2'd0, 2'd0);
        bus.pause_btn = 1'b0;
        watch("bounce_rel", 12, 0, 0, 1'b0, 1'b0, 2'd0, 2'd0);

        // Five level presses wrap 1,2,3,0,1
        for (int i = 0; i < 5; i++) begin
            bus.lev_btn = 1'b1;
            watch("lev_press", 10, 0, 7, 1'b0, 1'b0, (i == 0) ? 2'd0 : lev_tab[i-1], lev_tab[i]);
            bus.lev_btn = 1'b0;
            watch("lev_rel", 10, 0, 0, 1'b0, 1'b0, lev_tab[i], lev_tab[i]);
        end
        chk("lev_pulse_total", 8'(lev_pulses), 8'd5);

        // Release glitch must not produce a second strobe
        bus.pause_btn = 1'b1;
        watch("glitch_hold", 10, 7, 0, 1'b0, 1'b1, 2'd1, 2'd1);
        bus.pause_btn = 1'b0;
        watch("glitch_low", 2, 0, 0, 1'b1, 1'b1, 2'd1, 2'd1);
        bus.pause_btn = 1'b1;
        watch("glitch_rise", 15, 0, 0, 1'b1, 1'b1, 2'd1, 2'd1);
        bus.pause_btn = 1'b0;
        watch("glitch_rel", 12, 0, 0, 1'b1, 1'b1, 2'd1, 2'd1);

        // Reset clears pause_state and lev_sel, then simultaneous presses
        rst = 1'b1;
        tick();
        chk("rst2_pause_state", 8'(bus.pause_state), 8'h0);
        chk("rst2_lev_sel",     8'(bus.lev_sel),     8'h0);
        rst = 1'b0;
        bus.pause_btn = 1'b1;
        bus.lev_btn   = 1'b1;
        watch("simul", 10, 7, 7, 1'b0, 1'b1, 2'd0, 2'd1);
        bus.pause_btn = 1'b0;
        bus.lev_btn   = 1'b0;
        watch("simul_rel", 12, 0, 0, 1'b1, 1'b1, 2'd1, 2'd1);

        // Reset two cycles into PRESS_WAIT with the button still held
        bus.pause_btn = 1'b1;
        watch("mid_pre", 4, 0, 0, 1'b1, 1'b1, 2'd1, 2'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_pause_state", 8'(bus.pause_state), 8'h0);
        chk("mid_rst_pause_pulse", 8'(bus.pause_pulse), 8'h0);
        chk("mid_rst_lev_sel",     8'(bus.lev_sel),     8'h0);
        rst = 1'b0;
        watch("mid_post", 20, 7, 0, 1'b0, 1'b1, 2'd0, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
